div_issue_ctrl: RTL and testbench

//  EX-stage initiator for the multi-cycle divider. Accepts DIV/DIVU from EX, registers operands, drives the

---
 rtl/div_issue_ctrl_pkg.sv | 16 +
 rtl/div_issue_ctrl.sv | 105 ++++++++++
 tb/tb_div_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the divider issue controller:
// divider handshake levels, the zero word and controller states.
package div_issue_ctrl_pkg;

    localparam logic        DivStart       = 1'b1;
    localparam logic        DivStop        = 1'b0;
    localparam logic        DivResultReady = 1'b1;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } div_ctrl_state_t;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider.
// Ports: clk/rst (sync, active-high); ex_* DIV/DIVU request from EX;
// flush kills an in-flight divide; div_* drive/observe the divider;
// stall_req_o holds the pipeline; hilo_we_o/hi_o/lo_o write HI/LO;
// div_err_o is a sticky watchdog-abort flag.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int WATCHDOG = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_signed,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic        flush,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stall_req_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_err_o
);

    localparam int WdW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG - 1);

    div_ctrl_state_t state_q;
    logic [WdW-1:0]  wdog_q;

    // Stall starts in the accept cycle so EX cannot advance
    // past the divide before the operands are registered.
    assign stall_req_o = (state_q == WAIT) ||
                         ((state_q == IDLE) && ex_div_valid && !flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wdog_q        <= '0;
            div_start_o   <= DivStop;
            div_annul_o   <= 1'b0;
            div_signed_o  <= 1'b0;
            div_opdata1_o <= ZeroWord;
            div_opdata2_o <= ZeroWord;
            hilo_we_o     <= 1'b0;
            hi_o          <= ZeroWord;
            lo_o          <= ZeroWord;
            div_err_o     <= 1'b0;
        end else begin
            // Pulses: only the cycle after the event.
            div_annul_o <= 1'b0;
            hilo_we_o   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ex_div_valid && !flush) begin
                        div_opdata1_o <= ex_rs_data;
                        div_opdata2_o <= ex_rt_data;
                        div_signed_o  <= ex_signed;
                        div_start_o   <= DivStart;
                        wdog_q        <= '0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    // Flush wins over a same-cycle ready: the
                    // instruction is dead, so nothing is written.
                    if (flush) begin
                        div_start_o <= DivStop;
                        div_annul_o <= 1'b1;
                        state_q     <= IDLE;
                    end else if (div_ready_i == DivResultReady) begin
                        hi_o        <= div_result_i[63:32];
                        lo_o        <= div_result_i[31:0];
                        hilo_we_o   <= 1'b1;
                        div_start_o <= DivStop;
                        state_q     <= RELEASE;
                    end else if (wdog_q == WdLast) begin
                        div_start_o <= DivStop;
                        div_annul_o <= 1'b1;
                        div_err_o   <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // Write already committed; a flush here
                    // has nothing left to kill.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a 35-cycle behavioural
// divider and a scoreboard of expected HI/LO writes.
module tb_div_issue_ctrl;

    localparam int LAT = 35;

    logic        clk;
    logic        rst;
    logic        ex_div_valid;
    logic        ex_signed;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic        flush;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stall_req_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_err_o;

    int          nvec;
    int          nerr;
    logic [63:0] exp_q[$];
    logic        hold_ready;
    int          dcnt;
    logic        prev_start;
    logic        prev_annul;
    logic [64:0] held_ops;
    int          annul_cnt;

    div_issue_ctrl #(.WATCHDOG(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_valid (ex_div_valid),
        .ex_signed    (ex_signed),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .flush        (flush),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .stall_req_o  (stall_req_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div_err_o    (div_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: {rem, quo}, zero on divide by zero.
    function automatic logic [63:0] div_model(
        input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) begin
            q = 32'h0;
            r = 32'h0;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk) begin
        if (rst || !div_start_o || div_annul_o) dcnt <= 0;
        else if (dcnt != LAT) dcnt <= dcnt + 1;
    end

    assign div_ready_i  = div_start_o && (dcnt == LAT) && !hold_ready;
    assign div_result_i = div_model(div_signed_o, div_opdata1_o,
                                    div_opdata2_o);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops, operand hold, annul width.
    always @(negedge clk) begin
        if (rst) begin
            prev_start <= 1'b0;
            prev_annul <= 1'b0;
        end else begin
            if (div_start_o && prev_start)
                chk("opd_hold", {31'b0, div_signed_o, div_opdata1_o},
                    {31'b0, held_ops[64], held_ops[63:32]});
            if (div_start_o && prev_start)
                chk("opd2_hold", {32'b0, div_opdata2_o},
                    {32'b0, held_ops[31:0]});
            if (div_start_o && !prev_start)
                held_ops <= {div_signed_o, div_opdata1_o, div_opdata2_o};
            if (div_annul_o && prev_annul)
                chk("annul_width", 64'd2, 64'd1);
            if (div_annul_o) annul_cnt <= annul_cnt + 1;
            if (hilo_we_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {hi_o, lo_o}, 64'hx);
                end else begin
                    chk("hilo", {hi_o, lo_o}, exp_q.pop_front());
                end
            end
            prev_start <= div_start_o;
            prev_annul <= div_annul_o;
        end
    end

    // One-cycle request from EX; operands scrambled afterwards
    // so any re-read of EX data shows up.
    task automatic issue(input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] e,
                         input logic push);
        @(negedge clk);
        ex_div_valid = 1'b1;
        ex_signed    = s;
        ex_rs_data   = a;
        ex_rt_data   = b;
        if (push) exp_q.push_back(e);
        #1;
        chk("stall_accept", {63'b0, stall_req_o}, 64'd1);
        @(negedge clk);
        ex_div_valid = 1'b0;
        ex_signed    = ~s;
        ex_rs_data   = $urandom;
        ex_rt_data   = $urandom;
    endtask

    task automatic wait_release(input logic exp_we, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!stall_req_o) break;
            n++;
            @(negedge clk);
        end
        chk("stall_bound", {63'b0, n < 200}, 64'd1);
        chk("we_at_release", {63'b0, hilo_we_o}, {63'b0, exp_we});
    endtask

    int n;
    int ac;

    initial begin
        nvec = 0;
        nerr = 0;
        annul_cnt = 0;
        held_ops = '0;
        rst = 1'b1;
        ex_div_valid = 1'b0;
        ex_signed = 1'b0;
        ex_rs_data = 32'h0;
        ex_rt_data = 32'h0;
        flush = 1'b0;
        hold_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_start", {63'b0, div_start_o}, 64'd0);
        chk("rst_annul", {63'b0, div_annul_o}, 64'd0);
        chk("rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_we_err", {62'b0, hilo_we_o, div_err_o}, 64'd0);
        chk("rst_stall", {63'b0, stall_req_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // DIVU 100/7
        issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
        wait_release(1'b1, n);
        chk("divu_stall", 64'(n + 1), 64'd37);
        @(negedge clk);
        #1;
        chk("we_one_cycle", {63'b0, hilo_we_o}, 64'd0);

        // Signed divides incl. overflow case
        issue(1'b1, 32'hFFFF_FFF9, 32'd2,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
        wait_release(1'b1, n);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              {32'h0, 32'h8000_0000}, 1'b1);
        wait_release(1'b1, n);

        // Divide by zero
        issue(1'b0, 32'd5, 32'd0, 64'd0, 1'b1);
        wait_release(1'b1, n);
        chk("dz_stall", 64'(n + 1), 64'd37);
        chk("dz_no_err", {63'b0, div_err_o}, 64'd0);

        // Flush 10 cycles into WAIT
        ac = annul_cnt;
        issue(1'b0, 32'd123, 32'd4, 64'd0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_annul", {63'b0, div_annul_o}, 64'd1);
        chk("flush_stall", {63'b0, stall_req_o}, 64'd0);
        chk("flush_start", {63'b0, div_start_o}, 64'd0);
        @(negedge clk);
        #1;
        chk("flush_annul_end", {63'b0, div_annul_o}, 64'd0);
        chk("flush_annul_cnt", 64'(annul_cnt - ac), 64'd1);
        issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);
        wait_release(1'b1, n);

        // Flush in IDLE with a request: ignored
        @(negedge clk);
        ex_div_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("idle_flush_stall", {63'b0, stall_req_o}, 64'd0);
        @(negedge clk);
        ex_div_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("idle_flush_start", {63'b0, div_start_o}, 64'd0);

        // Back-to-back: RELEASE cycle, one IDLE cycle, restart
        issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
        wait_release(1'b1, n);
        chk("b2b_start_rel", {63'b0, div_start_o}, 64'd0);
        @(negedge clk);
        ex_div_valid = 1'b1;
        ex_rs_data = 32'd81;
        ex_rt_data = 32'd9;
        ex_signed = 1'b0;
        exp_q.push_back({32'd0, 32'd9});
        #1;
        chk("b2b_stall", {63'b0, stall_req_o}, 64'd1);
        chk("b2b_start_gap", {63'b0, div_start_o}, 64'd0);
        @(negedge clk);
        ex_div_valid = 1'b0;
        ex_rs_data = $urandom;
        #1;
        chk("b2b_start_again", {63'b0, div_start_o}, 64'd1);
        wait_release(1'b1, n);
        chk("b2b_stall2", 64'(n + 1), 64'd37);

        // Watchdog abort: divider never answers
        hold_ready = 1'b1;
        ac = annul_cnt;
        issue(1'b0, 32'd50, 32'd5, 64'd0, 1'b0);
        wait_release(1'b0, n);
        chk("wdog_cycles", 64'(n), 64'd64);
        chk("wdog_annul", {63'b0, div_annul_o}, 64'd1);
        chk("wdog_err", {63'b0, div_err_o}, 64'd1);
        hold_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("wdog_annul_end", {63'b0, div_annul_o}, 64'd0);
        chk("wdog_annul_cnt", 64'(annul_cnt - ac), 64'd1);
        chk("err_sticky", {63'b0, div_err_o}, 64'd1);

        // Sticky flag survives a good divide, cleared by rst
        issue(1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 1'b1);
        wait_release(1'b1, n);
        chk("err_sticky2", {63'b0, div_err_o}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("err_rst", {63'b0, div_err_o}, 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
